// File: rtl/mult_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// mult_operand_sequencer_if
//   Bundles the operand bus, the load/clear controls, the multiplier-facing
//   a/b/ea/eb/p_in signals and the result/status outputs of the operand
//   sequencer.
//   master : host side (drives din/load/clear, returns p_in from multiplier)
//   slave  : the sequencer itself
//   Signals:
//     din          N    operand data bus, synchronous to clk
//     load         1    level input, each rising edge advances the sequence
//     clear        1    synchronous abort back to operand-A capture
//     a, b         N    held operands to the multiplier
//     ea, eb       1    one-cycle load enables for the multiplier registers
//     p_in         2N   product coming back from the multiplier
//     result       2N   captured product
//     result_valid 1    product captured and held
//     busy         1    waiting out the multiplier latency
//     state_o      2    0=S_A 1=S_B 2=S_MULT 3=S_DONE
// ---------------------------------------------------------------------------
interface mult_operand_sequencer_if #(
   parameter int N = 8
);
   logic [N-1:0]   din;
   logic           load;
   logic           clear;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           ea;
   logic           eb;
   logic [2*N-1:0] p_in;
   logic [2*N-1:0] result;
   logic           result_valid;
   logic           busy;
   logic [1:0]     state_o;

   modport master (
      output din, load, clear, p_in,
      input  a, b, ea, eb, result, result_valid, busy, state_o
   );

   modport slave (
      input  din, load, clear, p_in,
      output a, b, ea, eb, result, result_valid, busy, state_o
   );
endinterface

// File: rtl/mult_operand_sequencer.sv
// ---------------------------------------------------------------------------
// mult_operand_sequencer
//   Control stage in front of a registered N-bit multiplier. One shared data
//   bus is captured as operand A, then operand B, on successive rising edges
//   of 'load'. The held operands and one-cycle ea/eb enables drive the
//   multiplier; after MULT_LAT cycles the 2N-bit product is captured into a
//   held result register and flagged valid.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      mult_operand_sequencer_if.slave (din, load, clear, p_in in;
//              a, b, ea, eb, result, result_valid, busy, state_o out)
//   Parameters:
//     N         operand width (product is 2N)
//     MULT_LAT  cycles from the ea/eb-high cycle to a valid p_in (>= 1)
// ---------------------------------------------------------------------------
module mult_operand_sequencer #(
   parameter int N        = 8,
   parameter int MULT_LAT = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   mult_operand_sequencer_if.slave bus
);

   // One extra bit keeps MULT_LAT-1 representable for every legal MULT_LAT.
   localparam int            CW       = $clog2(MULT_LAT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MULT_LAT - 1);

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_MULT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic           load_q;
   logic           ld_edge;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic           ea_q, ea_d;
   logic           eb_q, eb_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] res_q, res_d;
   logic           rv_q, rv_d;

   // A held level yields exactly one edge.
   assign ld_edge = bus.load & ~load_q;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_A;
      else          state_q <= state_d;
   end

   // ---------------- next state / datapath next values ----------------
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      ea_d    = 1'b0;      // enables are pulses: low unless set below
      eb_d    = 1'b0;
      cnt_d   = cnt_q;
      res_d   = res_q;
      rv_d    = rv_q;

      if (bus.clear) begin
         // Abort wins over a coincident load edge; operands stay put.
         state_d = S_A;
         res_d   = '0;
         rv_d    = 1'b0;
      end else begin
         case (state_q)
            S_A: begin
               if (ld_edge) begin
                  a_d     = bus.din;
                  ea_d    = 1'b1;
                  state_d = S_B;
               end
            end
            S_B: begin
               if (ld_edge) begin
                  b_d     = bus.din;
                  eb_d    = 1'b1;
                  cnt_d   = '0;     // cnt==0 lines up with the eb-high cycle
                  state_d = S_MULT;
               end
            end
            S_MULT: begin
               // Load edges here are dropped, not queued.
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  res_d   = bus.p_in;
                  rv_d    = 1'b1;
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               // Next operand A starts a new pass; the old product stays
               // visible in result until the next capture.
               if (ld_edge) begin
                  a_d     = bus.din;
                  ea_d    = 1'b1;
                  rv_d    = 1'b0;
                  state_d = S_B;
               end
            end
            default: state_d = S_A;
         endcase
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_q <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         ea_q   <= 1'b0;
         eb_q   <= 1'b0;
         cnt_q  <= '0;
         res_q  <= '0;
         rv_q   <= 1'b0;
      end else begin
         load_q <= bus.load;
         a_q    <= a_d;
         b_q    <= b_d;
         ea_q   <= ea_d;
         eb_q   <= eb_d;
         cnt_q  <= cnt_d;
         res_q  <= res_d;
         rv_q   <= rv_d;
      end
   end

   // ---------------- outputs ----------------
   assign bus.a            = a_q;
   assign bus.b            = b_q;
   assign bus.ea           = ea_q;
   assign bus.eb           = eb_q;
   assign bus.result       = res_q;
   assign bus.result_valid = rv_q;
   assign bus.busy         = (state_q == S_MULT);
   assign bus.state_o      = state_q;

endmodule
